// File: rtl/matvec_core_param.sv
// Parametrised streaming matrix-vector multiply core: y = W * x.
// Operands arrive one element per beat (W row-major, then x); results
// leave one row per beat. A single MAC is evaluated per COMPUTE cycle.
module matvec_core_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIM        = 4,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter bit          SIGNED     = 1'b0,
    parameter bit          SAT        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_reuse_w,
    input  logic                  snk_vld,
    input  logic [DATA_WIDTH-1:0] snk_data,
    output logic                  snk_rdy,
    output logic                  src_vld,
    output logic [ACC_WIDTH-1:0]  src_data,
    output logic                  src_last,
    input  logic                  src_rdy,
    output logic                  w_valid
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned ACC_I  = PROD_W + $clog2(DIM);
    localparam int unsigned NW     = DIM * DIM;
    localparam int unsigned CNT_W  = $clog2(NW);
    localparam int unsigned IDX_W  = $clog2(DIM);

    // Reject unsupported geometries at elaboration.
    if (DIM < 2 || DIM > 16 || ACC_WIDTH < 2) begin : g_bad_param
        $error("matvec_core_param: DIM must be 2..16 and ACC_WIDTH >= 2");
    end

    typedef enum logic [1:0] {
        S_LOAD_W,
        S_LOAD_X,
        S_COMPUTE,
        S_FLUSH
    } state_t;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [IDX_W-1:0]       r_row;
    logic [IDX_W-1:0]       r_col;
    logic [ACC_I-1:0]       r_acc;
    logic                   r_w_valid;
    logic                   r_snk_rdy;
    logic                   r_src_vld;
    logic [ACC_WIDTH-1:0]   r_src_data;
    logic                   r_src_last;

    logic [DATA_WIDTH-1:0]  r_w_mem   [NW];
    logic [DATA_WIDTH-1:0]  r_x_mem   [DIM];
    logic [ACC_WIDTH-1:0]   r_out_mem [DIM];

    logic [DATA_WIDTH-1:0]  w_w_op;
    logic [DATA_WIDTH-1:0]  w_x_op;
    logic [PROD_W-1:0]      w_w_ext;
    logic [PROD_W-1:0]      w_x_ext;
    logic [PROD_W-1:0]      w_prod;
    logic [ACC_I-1:0]       w_prod_ext;
    logic [ACC_I-1:0]       w_sum;
    logic [ACC_WIDTH-1:0]   w_narrow;

    assign snk_rdy  = r_snk_rdy;
    assign src_vld  = r_src_vld;
    assign src_data = r_src_data;
    assign src_last = r_src_last;
    assign w_valid  = r_w_valid;

    // During COMPUTE r_cnt walks the weight store linearly (r*DIM + c).
    assign w_w_op     = r_w_mem[r_cnt];
    assign w_x_op     = r_x_mem[r_col];
    assign w_w_ext    = {{DATA_WIDTH{SIGNED & w_w_op[DATA_WIDTH-1]}}, w_w_op};
    assign w_x_ext    = {{DATA_WIDTH{SIGNED & w_x_op[DATA_WIDTH-1]}}, w_x_op};
    assign w_prod     = PROD_W'(w_w_ext * w_x_ext);
    assign w_prod_ext = {{(ACC_I - PROD_W){SIGNED & w_prod[PROD_W-1]}}, w_prod};
    assign w_sum      = ((r_col == IDX_W'(0)) ? ACC_I'(0) : r_acc) + w_prod_ext;

    // Narrow the full-precision row sum to the output width.
    if (ACC_WIDTH > ACC_I) begin : g_ext
        assign w_narrow = {{(ACC_WIDTH - ACC_I){SIGNED & w_sum[ACC_I-1]}}, w_sum};
    end else if (ACC_WIDTH == ACC_I) begin : g_same
        assign w_narrow = w_sum;
    end else if (!SAT) begin : g_trunc
        assign w_narrow = w_sum[ACC_WIDTH-1:0];
    end else if (SIGNED) begin : g_sat_s
        logic [ACC_I-ACC_WIDTH:0] w_top;
        assign w_top    = w_sum[ACC_I-1:ACC_WIDTH-1];
        assign w_narrow = (&w_top || ~|w_top) ? w_sum[ACC_WIDTH-1:0] :
                          (w_sum[ACC_I-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}});
    end else begin : g_sat_u
        assign w_narrow = (|w_sum[ACC_I-1:ACC_WIDTH]) ? {ACC_WIDTH{1'b1}}
                                                      : w_sum[ACC_WIDTH-1:0];
    end

    // Operand and result storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD_W && snk_vld) begin
            r_w_mem[r_cnt] <= snk_data;
        end
        if (r_state == S_LOAD_X && snk_vld) begin
            r_x_mem[IDX_W'(r_cnt)] <= snk_data;
        end
        if (r_state == S_COMPUTE && r_col == IDX_W'(DIM - 1)) begin
            r_out_mem[r_row] <= w_narrow;
        end
    end

    // Control FSM with counters, accumulator and registered stream outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_LOAD_W;
            r_cnt      <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_w_valid  <= 1'b0;
            r_snk_rdy  <= 1'b1;
            r_src_vld  <= 1'b0;
            r_src_data <= '0;
            r_src_last <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD_W: begin
                    if (snk_vld) begin
                        if (r_cnt == CNT_W'(NW - 1)) begin
                            r_cnt     <= '0;
                            r_w_valid <= 1'b1;
                            r_state   <= S_LOAD_X;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_LOAD_X: begin
                    if (snk_vld) begin
                        if (r_cnt == CNT_W'(DIM - 1)) begin
                            r_cnt     <= '0;
                            r_row     <= '0;
                            r_col     <= '0;
                            r_snk_rdy <= 1'b0;
                            r_state   <= S_COMPUTE;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_COMPUTE: begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_col == IDX_W'(DIM - 1)) begin
                        r_col <= '0;
                        if (r_row == IDX_W'(DIM - 1)) begin
                            // Row 0 was written long ago, so it can be presented now.
                            r_row      <= '0;
                            r_cnt      <= '0;
                            r_src_vld  <= 1'b1;
                            r_src_data <= r_out_mem[IDX_W'(0)];
                            r_src_last <= 1'b0;
                            r_state    <= S_FLUSH;
                        end else begin
                            r_row <= r_row + IDX_W'(1);
                        end
                    end else begin
                        r_col <= r_col + IDX_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (src_rdy) begin
                        if (r_cnt == CNT_W'(DIM - 1)) begin
                            r_cnt      <= '0;
                            r_src_vld  <= 1'b0;
                            r_src_last <= 1'b0;
                            r_snk_rdy  <= 1'b1;
                            r_state    <= (cfg_reuse_w && r_w_valid) ? S_LOAD_X : S_LOAD_W;
                        end else begin
                            r_cnt      <= r_cnt + CNT_W'(1);
                            r_src_data <= r_out_mem[IDX_W'(r_cnt + CNT_W'(1))];
                            r_src_last <= (r_cnt + CNT_W'(1) == CNT_W'(DIM - 1));
                        end
                    end
                end
                default: r_state <= S_LOAD_W;
            endcase
        end
    end

endmodule

// File: tb/tb_matvec_core_param.sv
// Bench for matvec_core_param: five builds (unsigned/signed, wide/saturating/
// truncating) share one stimulus stream and are checked against a job table.
module tb_matvec_core_param;

    localparam int unsigned DIM = 4;
    localparam int unsigned NI  = 5;
    localparam int unsigned NJ  = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic           cfg_reuse_w = 1'b0;
    logic           snk_vld = 1'b0;
    logic [7:0]     snk_data = 8'h00;
    logic           src_rdy = 1'b0;

    logic [NI-1:0]  rdy;
    logic [NI-1:0]  vld;
    logic [NI-1:0]  last;
    logic [NI-1:0]  wv;
    logic [31:0]    d_u;
    logic [31:0]    d_s;
    logic [15:0]    d_sat;
    logic [15:0]    d_trn;
    logic [15:0]    d_ssat;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [15:0][7:0]  w;
        logic [3:0][7:0]   x;
        bit                skip_w;
        bit                reuse_next;
        logic [3:0][31:0]  y_u;
        logic [3:0][31:0]  y_s;
        logic [3:0][15:0]  y_sat;
        logic [3:0][15:0]  y_trn;
        logic [3:0][15:0]  y_ssat;
    } job_t;

    job_t jobs [NJ];

    always #5 clk = ~clk;

    matvec_core_param #(.DATA_WIDTH(8), .DIM(DIM), .ACC_WIDTH(32), .SIGNED(1'b0), .SAT(1'b1)) u_u (
        .clk(clk), .rst_n(rst_n), .cfg_reuse_w(cfg_reuse_w), .snk_vld(snk_vld), .snk_data(snk_data),
        .snk_rdy(rdy[0]), .src_vld(vld[0]), .src_data(d_u), .src_last(last[0]), .src_rdy(src_rdy), .w_valid(wv[0]));
    matvec_core_param #(.DATA_WIDTH(8), .DIM(DIM), .ACC_WIDTH(32), .SIGNED(1'b1), .SAT(1'b1)) u_s (
        .clk(clk), .rst_n(rst_n), .cfg_reuse_w(cfg_reuse_w), .snk_vld(snk_vld), .snk_data(snk_data),
        .snk_rdy(rdy[1]), .src_vld(vld[1]), .src_data(d_s), .src_last(last[1]), .src_rdy(src_rdy), .w_valid(wv[1]));
    matvec_core_param #(.DATA_WIDTH(8), .DIM(DIM), .ACC_WIDTH(16), .SIGNED(1'b0), .SAT(1'b1)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_reuse_w(cfg_reuse_w), .snk_vld(snk_vld), .snk_data(snk_data),
        .snk_rdy(rdy[2]), .src_vld(vld[2]), .src_data(d_sat), .src_last(last[2]), .src_rdy(src_rdy), .w_valid(wv[2]));
    matvec_core_param #(.DATA_WIDTH(8), .DIM(DIM), .ACC_WIDTH(16), .SIGNED(1'b0), .SAT(1'b0)) u_trn (
        .clk(clk), .rst_n(rst_n), .cfg_reuse_w(cfg_reuse_w), .snk_vld(snk_vld), .snk_data(snk_data),
        .snk_rdy(rdy[3]), .src_vld(vld[3]), .src_data(d_trn), .src_last(last[3]), .src_rdy(src_rdy), .w_valid(wv[3]));
    matvec_core_param #(.DATA_WIDTH(8), .DIM(DIM), .ACC_WIDTH(16), .SIGNED(1'b1), .SAT(1'b1)) u_ssat (
        .clk(clk), .rst_n(rst_n), .cfg_reuse_w(cfg_reuse_w), .snk_vld(snk_vld), .snk_data(snk_data),
        .snk_rdy(rdy[4]), .src_vld(vld[4]), .src_data(d_ssat), .src_last(last[4]), .src_rdy(src_rdy), .w_valid(wv[4]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_of(input int inst);
        case (inst)
            0:       return d_u;
            1:       return d_s;
            2:       return {16'h0, d_sat};
            3:       return {16'h0, d_trn};
            default: return {16'h0, d_ssat};
        endcase
    endfunction

    function automatic logic [31:0] exp_of(input job_t jb, input int inst, input int r);
        case (inst)
            0:       return jb.y_u[r];
            1:       return jb.y_s[r];
            2:       return {16'h0, jb.y_sat[r]};
            3:       return {16'h0, jb.y_trn[r]};
            default: return {16'h0, jb.y_ssat[r]};
        endcase
    endfunction

    task automatic set_y(input int j, input int r, input logic [31:0] yu, input logic [31:0] ys,
                         input logic [15:0] ysat, input logic [15:0] ytrn, input logic [15:0] yssat);
        jobs[j].y_u[r]    = yu;
        jobs[j].y_s[r]    = ys;
        jobs[j].y_sat[r]  = ysat;
        jobs[j].y_trn[r]  = ytrn;
        jobs[j].y_ssat[r] = yssat;
    endtask

    // One input beat; waits (bounded) for snk_rdy, returns just after the transfer edge.
    task automatic send_beat(input logic [7:0] d);
        int t;
        t = 0;
        @(negedge clk);
        snk_vld  = 1'b1;
        snk_data = d;
        while (!rdy[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!rdy[0]) check("snk_rdy_timeout", 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic load_operands(input job_t jb, input int j);
        if (jb.skip_w) begin
            @(negedge clk);
            check($sformatf("job%0d reuse snk_rdy in LOAD_X", j), 32'(rdy[0]), 32'd1);
            check($sformatf("job%0d reuse w_valid", j), 32'(wv), 32'h1f);
        end else begin
            for (int i = 0; i < 16; i++) send_beat(jb.w[i]);
            check($sformatf("job%0d w_valid after W", j), 32'(wv), 32'h1f);
        end
        for (int i = 0; i < DIM; i++) send_beat(jb.x[i]);
    endtask

    // Latency measurement, ignored input during COMPUTE, then the output stream.
    task automatic run_tail(input job_t jb, input int j);
        int k;
        int lat;
        int b;
        int t;
        int stall;
        k   = 0;
        lat = -1;
        while (k < 100) begin
            @(negedge clk);
            snk_vld  = (k >= 2 && k <= 5);
            snk_data = 8'hAA;
            if (k == 3) check($sformatf("job%0d snk_rdy in COMPUTE", j), 32'(rdy), 32'h0);
            if (vld[0]) begin
                lat = k + 1;
                break;
            end
            @(posedge clk);
            k++;
        end
        snk_vld = 1'b0;
        check($sformatf("job%0d first src_vld edge after last x", j), 32'(lat), 32'(DIM * DIM + 1));
        b     = 0;
        t     = 0;
        stall = 0;
        while (b < DIM && t < 200) begin
            if (b == 1 && stall < 3) begin
                src_rdy = 1'b0;
                stall++;
                check($sformatf("job%0d stall%0d data hold", j, stall), d_u, jb.y_u[1]);
                check($sformatf("job%0d stall%0d last hold", j, stall), 32'(last[0]), 32'd0);
            end else begin
                src_rdy = 1'($urandom_range(0, 1));
            end
            cfg_reuse_w = (b == DIM - 1) ? jb.reuse_next : !jb.reuse_next;
            if (vld[0] && src_rdy) begin
                for (int i = 0; i < NI; i++) begin
                    check($sformatf("job%0d inst%0d y[%0d]", j, i, b), act_of(i), exp_of(jb, i, b));
                    check($sformatf("job%0d inst%0d last[%0d]", j, i, b), 32'(last[i]), 32'(b == DIM - 1));
                end
                b++;
            end
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        src_rdy = 1'b0;
        check($sformatf("job%0d beats emitted", j), 32'(b), 32'(DIM));
        check($sformatf("job%0d src_vld low after flush", j), 32'(vld), 32'h0);
        check($sformatf("job%0d snk_rdy high after flush", j), 32'(rdy), 32'h1f);
    endtask

    initial begin
        // Job table.
        for (int j = 0; j < NJ; j++) begin
            jobs[j].skip_w     = 1'b0;
            jobs[j].reuse_next = 1'b0;
            jobs[j].w          = '0;
            jobs[j].x          = '0;
        end
        // 0: identity
        for (int i = 0; i < 16; i++) jobs[0].w[i] = (i % 5 == 0) ? 8'd1 : 8'd0;
        for (int i = 0; i < 4; i++) begin
            jobs[0].x[i] = 8'(i + 1);
            set_y(0, i, 32'(i + 1), 32'(i + 1), 16'(i + 1), 16'(i + 1), 16'(i + 1));
        end
        // 1: W all 0xFF, x = 1..4
        for (int i = 0; i < 16; i++) jobs[1].w[i] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            jobs[1].x[i] = 8'(i + 1);
            set_y(1, i, 32'd2550, 32'hFFFF_FFF6, 16'h09F6, 16'h09F6, 16'hFFF6);
        end
        // 2: W and x all 0xFF
        for (int i = 0; i < 16; i++) jobs[2].w[i] = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            jobs[2].x[i] = 8'hFF;
            set_y(2, i, 32'h0003_F804, 32'd4, 16'hFFFF, 16'hF804, 16'h0004);
        end
        // 3: W all 0x80, x all 0x7F (large negative in signed builds)
        for (int i = 0; i < 16; i++) jobs[3].w[i] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            jobs[3].x[i] = 8'h7F;
            set_y(3, i, 32'h0000_FE00, 32'hFFFF_0200, 16'hFE00, 16'hFE00, 16'h8000);
        end
        // 4: W all ones, x = 1..4, keep weights for job 5
        for (int i = 0; i < 16; i++) jobs[4].w[i] = 8'd1;
        jobs[4].reuse_next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            jobs[4].x[i] = 8'(i + 1);
            set_y(4, i, 32'd10, 32'd10, 16'd10, 16'd10, 16'd10);
        end
        // 5: reuse weights, x = 5..8
        jobs[5].skip_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
            jobs[5].x[i] = 8'(i + 5);
            set_y(5, i, 32'd26, 32'd26, 16'd26, 16'd26, 16'd26);
        end
        // 6: W = 1..16 row-major, x = [1,1,2,2] -> distinct rows
        for (int i = 0; i < 16; i++) jobs[6].w[i] = 8'(i + 1);
        jobs[6].x[0] = 8'd1;
        jobs[6].x[1] = 8'd1;
        jobs[6].x[2] = 8'd2;
        jobs[6].x[3] = 8'd2;
        set_y(6, 0, 32'd17, 32'd17, 16'd17, 16'd17, 16'd17);
        set_y(6, 1, 32'd41, 32'd41, 16'd41, 16'd41, 16'd41);
        set_y(6, 2, 32'd65, 32'd65, 16'd65, 16'd65, 16'd65);
        set_y(6, 3, 32'd89, 32'd89, 16'd89, 16'd89, 16'd89);

        // Power-on reset.
        #3 rst_n = 1'b0;
        #1;
        check("reset snk_rdy", 32'(rdy), 32'h1f);
        check("reset src_vld", 32'(vld), 32'h0);
        check("reset src_last", 32'(last), 32'h0);
        check("reset w_valid", 32'(wv), 32'h0);
        for (int i = 0; i < NI; i++) check($sformatf("reset inst%0d src_data", i), act_of(i), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven jobs.
        for (int j = 0; j < NJ; j++) begin
            load_operands(jobs[j], j);
            run_tail(jobs[j], j);
        end

        // Reset in the middle of COMPUTE; weights must be reloaded afterwards.
        load_operands(jobs[4], 40);
        snk_vld = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset snk_rdy", 32'(rdy), 32'h1f);
        check("midreset src_vld", 32'(vld), 32'h0);
        check("midreset src_last", 32'(last), 32'h0);
        check("midreset w_valid", 32'(wv), 32'h0);
        check("midreset src_data", d_u, 32'h0);
        @(negedge clk);
        rst_n       = 1'b1;
        cfg_reuse_w = 1'b1;
        @(negedge clk);
        check("post-reset w_valid", 32'(wv), 32'h0);
        load_operands(jobs[6], 60);
        run_tail(jobs[6], 60);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    // Absolute time limit.
    initial begin
        #200000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
